draw_sequencer: RTL and testbench

//  Upstream scheduler for the card_position/draw_and_erase sprite path. Accepts draw commands from the game FSM,

---
 rtl/draw_sequencer_pkg.sv | 56 +++++
 rtl/draw_sequencer_cmd_fifo.sv | 52 +++++
 rtl/draw_sequencer.sv | 153 +++++++++++++++
 tb/tb_draw_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_sequencer_pkg.sv
// Shared definitions for the sprite draw sequencer: command field widths,
// sprite kind codes, slot/rank limits, FSM encoding and the command
// legality check.
package draw_sequencer_pkg;

    localparam int unsigned KIND_W = 3;
    localparam int unsigned NUM_W  = 4;
    localparam int unsigned SUIT_W = 2;
    localparam int unsigned POS_W  = 4;
    localparam int unsigned CMD_W  = KIND_W + NUM_W + SUIT_W + POS_W;
    localparam int unsigned CNT_W  = 12;

    localparam logic [KIND_W-1:0] KIND_FACE = 3'd0;
    localparam logic [KIND_W-1:0] KIND_BACK = 3'd1;
    localparam logic [KIND_W-1:0] KIND_P1   = 3'd2;
    localparam logic [KIND_W-1:0] KIND_P2   = 3'd3;

    localparam int unsigned SLOT_COUNT = 11;
    localparam int unsigned RANK_MIN   = 1;
    localparam int unsigned RANK_MAX   = 13;

    // One queued draw request, packed in FIFO storage order.
    typedef struct packed {
        logic [KIND_W-1:0] kind;
        logic [NUM_W-1:0]  num;
        logic [SUIT_W-1:0] suit;
        logic [POS_W-1:0]  pos;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_DRAW,
        ST_DONE,
        ST_ABORT
    } state_t;

    // Rank is only meaningful for face cards; every kind needs a valid slot.
    function automatic logic cmd_legal(input cmd_t c);
        logic ok;
        ok = 1'b0;
        case (c.kind)
            KIND_FACE: ok = (c.num >= NUM_W'(RANK_MIN)) && (c.num <= NUM_W'(RANK_MAX));
            KIND_BACK,
            KIND_P1,
            KIND_P2:   ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        if (c.pos >= POS_W'(SLOT_COUNT)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/draw_sequencer_cmd_fifo.sv
// Command buffer for the draw sequencer: small show-ahead FIFO.
// Ports: clk, resetn (sync, active-low); push/din write when not full;
// pop advances the head when not empty; dout is the current head;
// full/empty status flags.
module draw_sequencer_cmd_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer separates full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; push and pop may occur together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage, not reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// Draw sequencer: queues sprite draw commands from the game FSM and plays
// them out one at a time to card_position / VGA plot.
// Ports: clk, resetn (sync, active-low); cmd_valid/cmd_ready handshake with
// cmd_kind/num/suit/pos fields; draw_sel/card_num/card_suit/card_pos held
// selection to card_position; sprite_rst counter reset; draw_finished from
// card_position; plot VGA enable; busy status; done/err one-cycle pulses.
module draw_sequencer
    import draw_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 4095
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [KIND_W-1:0] cmd_kind,
    input  logic [NUM_W-1:0]  cmd_num,
    input  logic [SUIT_W-1:0] cmd_suit,
    input  logic [POS_W-1:0]  cmd_pos,
    output logic [KIND_W-1:0] draw_sel,
    output logic [NUM_W-1:0]  card_num,
    output logic [SUIT_W-1:0] card_suit,
    output logic [POS_W-1:0]  card_pos,
    output logic              sprite_rst,
    input  logic              draw_finished,
    output logic              plot,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t           state;
    state_t           state_next;
    cmd_t             in_cmd;
    cmd_t             head;
    logic [CMD_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ready_q;
    logic             plot_en;
    logic             accept_c;
    logic             push_c;
    logic             reject_c;
    logic             pop_c;
    logic [CNT_W-1:0] cyc_cnt;

    assign in_cmd   = '{kind: cmd_kind, num: cmd_num, suit: cmd_suit, pos: cmd_pos};
    assign head     = cmd_t'(fifo_dout);
    assign accept_c = cmd_valid && cmd_ready;
    assign push_c   = accept_c && cmd_legal(in_cmd);
    assign reject_c = accept_c && !cmd_legal(in_cmd);

    // Ready is held low through reset and whenever the buffer is full.
    assign cmd_ready = ready_q && !fifo_full;
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    // Plot drops in the same cycle draw_finished rises.
    assign plot      = plot_en && !draw_finished;

    draw_sequencer_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_c),
        .din    (in_cmd),
        .pop    (pop_c),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and FIFO pop decode.
    always_comb begin
        state_next = state;
        pop_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_LOAD;
                    pop_c      = 1'b1;
                end
            end
            ST_LOAD:  state_next = ST_CLEAR;
            ST_CLEAR: begin
                if (cyc_cnt >= CNT_W'(CLR_CYCLES - 1)) begin
                    state_next = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (draw_finished) begin
                    state_next = ST_DONE;
                end else if (cyc_cnt >= CNT_W'(TIMEOUT - 1)) begin
                    state_next = ST_ABORT;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_ABORT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Per-state cycle counter: restarts on every state change, saturates.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cyc_cnt <= '0;
        end else if (state_next != state) begin
            cyc_cnt <= '0;
        end else if (cyc_cnt != {CNT_W{1'b1}}) begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
        end
    end

    // Registered outputs derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q    <= 1'b0;
            draw_sel   <= KIND_BACK;
            card_num   <= NUM_W'(RANK_MIN);
            card_suit  <= '0;
            card_pos   <= '0;
            sprite_rst <= 1'b1;
            plot_en    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            ready_q    <= 1'b1;
            sprite_rst <= (state_next != ST_DRAW);
            plot_en    <= (state_next == ST_DRAW);
            done       <= (state_next == ST_DONE);
            err        <= reject_c || (state_next == ST_ABORT);
            // Selection is captured at the pop and held until the next one.
            if (pop_c) begin
                draw_sel  <= head.kind;
                card_num  <= head.num;
                card_suit <= head.suit;
                card_pos  <= head.pos;
            end
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: card_position stub, scoreboard of expected
// draws popped on each completion, directed scenarios.
module tb_draw_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_kind = '0;
    logic [3:0] cmd_num = '0;
    logic [1:0] cmd_suit = '0;
    logic [3:0] cmd_pos = '0;
    logic [2:0] draw_sel;
    logic [3:0] card_num;
    logic [1:0] card_suit;
    logic [3:0] card_pos;
    logic       sprite_rst;
    logic       draw_finished = 1'b0;
    logic       plot;
    logic       busy;
    logic       done;
    logic       err;

    typedef struct {
        logic [2:0] kind;
        logic [3:0] num;
        logic [1:0] suit;
        logic [3:0] pos;
        bit         exp_done;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   reject_cnt = 0;
    int   draw_len = 0;
    int   fin_cnt = 0;
    bit   drew = 1'b0;
    bit   hold_ok = 1'b1;
    logic plot_prev = 1'b0;

    always #5 clk = ~clk;

    draw_sequencer dut (
        .clk           (clk),
        .resetn        (resetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_kind      (cmd_kind),
        .cmd_num       (cmd_num),
        .cmd_suit      (cmd_suit),
        .cmd_pos       (cmd_pos),
        .draw_sel      (draw_sel),
        .card_num      (card_num),
        .card_suit     (card_suit),
        .card_pos      (card_pos),
        .sprite_rst    (sprite_rst),
        .draw_finished (draw_finished),
        .plot          (plot),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // card_position stub: finishes once sprite_rst has been low for more
    // than draw_len cycles; draw_len == 0 stalls forever.
    always @(posedge clk) begin
        #1;
        if (sprite_rst !== 1'b0) begin
            fin_cnt       = 0;
            draw_finished = 1'b0;
        end else begin
            fin_cnt++;
            draw_finished = (draw_len != 0) && (fin_cnt > draw_len);
        end
    end

    // Output monitor: every draw must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (plot === 1'b1 && plot_prev !== 1'b1) begin
                check("draw_has_cmd", 32'(sb.size() > 0), 1);
                drew    = 1'b1;
                hold_ok = 1'b1;
            end
            if (plot === 1'b1 && sb.size() > 0) begin
                if (draw_sel !== sb[0].kind || card_num !== sb[0].num ||
                    card_suit !== sb[0].suit || card_pos !== sb[0].pos) begin
                    hold_ok = 1'b0;
                end
            end
            if (done === 1'b1 || err === 1'b1) begin
                if (drew) begin
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("outcome_done", 32'(done), 32'(e.exp_done));
                        check("draw_sel", 32'(draw_sel), 32'(e.kind));
                        check("card_num", 32'(card_num), 32'(e.num));
                        check("card_suit", 32'(card_suit), 32'(e.suit));
                        check("card_pos", 32'(card_pos), 32'(e.pos));
                        check("sel_held", 32'(hold_ok), 1);
                    end
                    drew = 1'b0;
                end else begin
                    check("done_needs_draw", 32'(done), 0);
                    reject_cnt++;
                end
                if (done === 1'b1) done_cnt++;
            end
        end
        plot_prev = plot;
    end

    // Offer a command and hold it until accepted (bounded).
    task automatic send(input int k, input int n, input int s, input int p,
                        input bit legal, input bit exp_done, output int waited);
        exp_t x;
        cmd_kind  = 3'(k);
        cmd_num   = 4'(n);
        cmd_suit  = 2'(s);
        cmd_pos   = 4'(p);
        cmd_valid = 1'b1;
        waited    = 0;
        while (cmd_ready !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("ready_within_bound", 32'(waited < 300), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (legal) begin
            x.kind = 3'(k); x.num = 4'(n); x.suit = 2'(s); x.pos = 4'(p);
            x.exp_done = exp_done;
            sb.push_back(x);
        end
    endtask

    task automatic wait_plot(output int lat);
        lat = 0;
        @(negedge clk);
        while (plot !== 1'b1 && lat < 100) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_len(output int n);
        n = 0;
        while (plot === 1'b1 && n < 6000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int b;
        b = 0;
        while (done_cnt < target && b < budget) begin
            @(posedge clk);
            b++;
        end
        check("done_count", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        int lat;
        int n;
        int base;

        // Reset held for three edges.
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_plot", 32'(plot), 0);
        check("rst_sprite_rst", 32'(sprite_rst), 1);
        check("rst_draw_sel", 32'(draw_sel), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready_low", 32'(cmd_ready), 0);
        check("rst_done_err", 32'({done, err}), 0);
        resetn = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 1);
        check("rst_card_fields", 32'({card_num, card_suit, card_pos}), 32'({4'd1, 2'd0, 4'd0}));

        // Single face card, 910-cycle sprite.
        draw_len = 910;
        send(0, 12, 1, 4, 1'b1, 1'b1, w);
        wait_plot(lat);
        check("accept_to_draw", 32'(lat), 4);
        check("face_sel", 32'({draw_sel, card_num, card_suit, card_pos}),
              32'({3'd0, 4'd12, 2'd1, 4'd4}));
        check("draw_sprite_rst", 32'(sprite_rst), 0);
        run_len(n);
        check("plot_cycles", 32'(n), 910);
        wait_done(1, 20);
        repeat (5) @(negedge clk);
        check("done_single", 32'(done_cnt), 1);
        check("idle_busy", 32'(busy), 0);
        check("idle_sprite_rst", 32'(sprite_rst), 1);

        // Fill the buffer behind a stalled draw.
        draw_len = 0;
        base = done_cnt;
        send(0, 1, 0, 0, 1'b1, 1'b1, w);
        send(0, 13, 3, 10, 1'b1, 1'b1, w);
        send(1, 0, 2, 5, 1'b1, 1'b1, w);
        send(3, 0, 1, 10, 1'b1, 1'b1, w);
        send(0, 7, 2, 8, 1'b1, 1'b1, w);
        cmd_kind = 3'd2; cmd_num = 4'd0; cmd_suit = 2'd0; cmd_pos = 4'd9;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("full_ready_low", 32'(cmd_ready), 0);
        repeat (10) @(negedge clk);
        check("full_ready_still_low", 32'(cmd_ready), 0);
        check("full_busy", 32'(busy), 1);
        draw_len = 30;
        send(2, 0, 0, 9, 1'b1, 1'b1, w);
        check("waited_for_pop", 32'(w > 0), 1);
        wait_done(base + 6, 2000);
        repeat (3) @(negedge clk);
        check("b2b_sb_empty", 32'(sb.size()), 0);
        check("b2b_busy", 32'(busy), 0);

        // Illegal commands are dropped with an err pulse.
        base = reject_cnt;
        send(4, 1, 0, 0, 1'b0, 1'b0, w);
        @(negedge clk);
        check("ill_kind_err", 32'(err), 1);
        check("ill_kind_ready", 32'(cmd_ready), 1);
        send(0, 0, 0, 0, 1'b0, 1'b0, w);
        @(negedge clk);
        check("ill_num_err", 32'(err), 1);
        send(1, 0, 0, 11, 1'b0, 1'b0, w);
        @(negedge clk);
        check("ill_pos_err", 32'(err), 1);
        repeat (4) @(negedge clk);
        check("ill_busy", 32'(busy), 0);
        check("ill_plot", 32'(plot), 0);
        check("ill_reject_count", 32'(reject_cnt - base), 3);

        // Timeout on a stalled banner, then a queued banner proceeds.
        draw_len = 0;
        base = done_cnt;
        send(2, 0, 0, 9, 1'b1, 1'b0, w);
        send(3, 0, 0, 10, 1'b1, 1'b1, w);
        wait_plot(lat);
        check("to_accept_to_draw", 32'(lat), 3);
        run_len(n);
        check("to_plot_cycles", 32'(n), 4095);
        check("to_err", 32'(err), 1);
        check("to_plot_low", 32'(plot), 0);
        check("to_no_done", 32'(done), 0);
        draw_len = 5;
        wait_done(base + 1, 100);

        // Reset in the middle of a draw.
        repeat (3) @(negedge clk);
        draw_len = 0;
        base = done_cnt;
        send(1, 0, 3, 2, 1'b1, 1'b1, w);
        send(0, 5, 2, 6, 1'b1, 1'b1, w);
        wait_plot(lat);
        repeat (499) @(negedge clk);
        check("mid_plot_before_rst", 32'(plot), 1);
        resetn = 1'b0;
        @(negedge clk);
        sb.delete();
        drew = 1'b0;
        check("mid_rst_plot", 32'(plot), 0);
        check("mid_rst_done_err", 32'({done, err}), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_sprite_rst", 32'(sprite_rst), 1);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_plot", 32'(plot), 0);
        check("post_rst_no_done", 32'(done_cnt - base), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
